// File: rtl/hdc_feature_window.sv
// hdc_feature_window
//
// Upstream stage of the HDC sensor-fusion core. Accepts one feature vector per
// handshake and presents the three-sample sliding window
// {F[n], F[n-1], F[n-2]} (newest in the MSBs) to the fusion core. The two
// older slots are zero-filled for the first two windows of a session.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   feature_in     newest sample vector (FEAT_W bits)
//   feature_valid  feature_in is valid
//   feature_ready  block can accept feature_in this cycle
//   session_clear  synchronous flush of history, pending window and counter
//   features_top   {newest, previous, oldest} window (3*FEAT_W bits)
//   fin_valid      features_top holds an undelivered window
//   fin_ready      fusion core accepts the window
//   window_warm    all three slots of the presented window are real samples
//   window_count   windows delivered since reset/clear, saturating

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module hdc_feature_window #(
    parameter int TOTAL_NUM_CHANNEL = `TOTAL_NUM_CHANNEL,
    parameter int CHANNEL_WIDTH     = `CHANNEL_WIDTH,
    parameter int COUNT_WIDTH       = 16,
    localparam int FEAT_W           = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FEAT_W-1:0]       feature_in,
    input  logic                    feature_valid,
    output logic                    feature_ready,
    input  logic                    session_clear,
    output logic [3*FEAT_W-1:0]     features_top,
    output logic                    fin_valid,
    input  logic                    fin_ready,
    output logic                    window_warm,
    output logic [COUNT_WIDTH-1:0]  window_count
);

    localparam logic [1:0] FILL_FULL = 2'd2;

    logic [FEAT_W-1:0]      h1_q, h1_d;
    logic [FEAT_W-1:0]      h2_q, h2_d;
    logic [1:0]             fill_q, fill_d;
    logic [3*FEAT_W-1:0]    top_q, top_d;
    logic                   valid_q, valid_d;
    logic                   warm_q, warm_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic                   accept;
    logic                   deliver;
    logic [3*FEAT_W-1:0]    window_next;

    // Slot 2 is the incoming sample, slot 1 the last accepted one, slot 0 the
    // one before; slot index maps directly onto the packed window position.
    logic [FEAT_W-1:0] slot [3];
    assign slot[2] = feature_in;
    assign slot[1] = h1_q;
    assign slot[0] = h2_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pack
            assign window_next[gi*FEAT_W +: FEAT_W] = slot[gi];
        end
    endgenerate

    // Single pipeline register with pass-through ready: a stalled window blocks
    // new input, but a window being delivered this cycle can be replaced.
    assign feature_ready = ~rst & ~session_clear & (~valid_q | fin_ready);
    assign accept        = feature_valid & feature_ready;
    assign deliver       = valid_q & fin_ready;

    always_comb begin
        h1_d    = h1_q;
        h2_d    = h2_q;
        fill_d  = fill_q;
        top_d   = top_q;
        valid_d = valid_q;
        warm_d  = warm_q;
        count_d = count_q;

        if (accept) begin
            top_d   = window_next;
            h2_d    = h1_q;
            h1_d    = feature_in;
            warm_d  = (fill_q == FILL_FULL);
            fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 2'd1;
            valid_d = 1'b1;
        end else if (deliver) begin
            valid_d = 1'b0;
        end

        if (deliver && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end

        // Clear wins over any handshake in the same cycle; a pending window is
        // dropped without being counted.
        if (session_clear) begin
            h1_d    = '0;
            h2_d    = '0;
            fill_d  = '0;
            top_d   = '0;
            valid_d = 1'b0;
            warm_d  = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q    <= '0;
            h2_q    <= '0;
            fill_q  <= '0;
            top_q   <= '0;
            valid_q <= 1'b0;
            warm_q  <= 1'b0;
            count_q <= '0;
        end else begin
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            fill_q  <= fill_d;
            top_q   <= top_d;
            valid_q <= valid_d;
            warm_q  <= warm_d;
            count_q <= count_d;
        end
    end

    assign features_top = top_q;
    assign fin_valid    = valid_q;
    assign window_warm  = warm_q;
    assign window_count = count_q;

endmodule

// File: tb/tb_hdc_feature_window.sv
// Testbench for hdc_feature_window: directed stimulus with a scoreboard queue
// filled at each accept and drained by an independent monitor at every
// delivery handshake. A second instance with a 3-bit counter shares the same
// stimulus to cover counter saturation.

module tb_hdc_feature_window;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int FW  = NCH * CW;
    localparam int WW  = 3 * FW;

    typedef struct packed {
        logic [WW-1:0] win;
        logic          warm;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] feature_in;
    logic          feature_valid;
    logic          feature_ready;
    logic          session_clear;
    logic [WW-1:0] features_top;
    logic          fin_valid;
    logic          fin_ready;
    logic          window_warm;
    logic [15:0]   window_count;

    logic          s_feature_ready;
    logic [WW-1:0] s_features_top;
    logic          s_fin_valid;
    logic          s_window_warm;
    logic [2:0]    s_window_count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    logic [FW-1:0] m_h1, m_h2;
    int            m_fill;

    always #5 clk = ~clk;

    hdc_feature_window #(
        .TOTAL_NUM_CHANNEL(NCH), .CHANNEL_WIDTH(CW), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .feature_in(feature_in),
        .feature_valid(feature_valid), .feature_ready(feature_ready),
        .session_clear(session_clear), .features_top(features_top),
        .fin_valid(fin_valid), .fin_ready(fin_ready),
        .window_warm(window_warm), .window_count(window_count)
    );

    hdc_feature_window #(
        .TOTAL_NUM_CHANNEL(NCH), .CHANNEL_WIDTH(CW), .COUNT_WIDTH(3)
    ) dut_sat (
        .clk(clk), .rst(rst), .feature_in(feature_in),
        .feature_valid(feature_valid), .feature_ready(s_feature_ready),
        .session_clear(session_clear), .features_top(s_features_top),
        .fin_valid(s_fin_valid), .fin_ready(fin_ready),
        .window_warm(s_window_warm), .window_count(s_window_count)
    );

    task automatic check(input string name, input logic [WW-1:0] act,
                         input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [WW-1:0] win3(input logic [FW-1:0] a,
                                           input logic [FW-1:0] b,
                                           input logic [FW-1:0] c);
        return {a, b, c};
    endfunction

    task automatic model_reset();
        m_h1   = '0;
        m_h2   = '0;
        m_fill = 0;
        sb_q.delete();
    endtask

    task automatic model_accept(input logic [FW-1:0] x);
        exp_t e;
        e.win  = {x, m_h1, m_h2};
        e.warm = (m_fill == 2);
        sb_q.push_back(e);
        m_h2   = m_h1;
        m_h1   = x;
        if (m_fill < 2) m_fill++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present x until accepted (bounded), then verify 1-cycle latency.
    task automatic send(input logic [FW-1:0] x);
        bit got;
        got           = 1'b0;
        feature_valid = 1'b1;
        feature_in    = x;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (feature_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: feature_ready stuck 0 for 0x%0h, required 1", x);
        end else begin
            model_accept(x);
        end
        tick();
        feature_valid = 1'b0;
        if (got) check("latency_fin_valid", WW'(fin_valid), WW'(1));
    endtask

    task automatic do_clear();
        fin_ready     = 1'b0;
        session_clear = 1'b1;
        tick();
        session_clear = 1'b0;
        model_reset();
        check("clear_fin_valid", WW'(fin_valid), WW'(0));
        check("clear_count", WW'(window_count), WW'(0));
        check("clear_top", features_top, WW'(0));
    endtask

    // Monitor: every delivery handshake must match the oldest expected window.
    always @(negedge clk) begin
        if (!rst && !session_clear && fin_valid && fin_ready) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_extra: window 0x%0h delivered, none expected", features_top);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_window", features_top, e.win);
                check("sb_warm", WW'(window_warm), WW'(e.warm));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        feature_in    = '0;
        feature_valid = 1'b0;
        session_clear = 1'b0;
        fin_ready     = 1'b0;
        model_reset();
        tick();
        tick();

        // Reset state
        check("rst_ready", WW'(feature_ready), WW'(0));
        check("rst_top", features_top, WW'(0));
        check("rst_valid", WW'(fin_valid), WW'(0));
        check("rst_warm", WW'(window_warm), WW'(0));
        check("rst_count", WW'(window_count), WW'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", WW'(feature_ready), WW'(1));

        // Warm-up
        fin_ready = 1'b1;
        send(32'h01);
        check("warm0_top", features_top, win3(32'h01, 32'h00, 32'h00));
        check("warm0_warm", WW'(window_warm), WW'(0));
        send(32'h02);
        check("warm1_top", features_top, win3(32'h02, 32'h01, 32'h00));
        check("warm1_warm", WW'(window_warm), WW'(0));
        send(32'h03);
        check("warm2_top", features_top, win3(32'h03, 32'h02, 32'h01));
        check("warm2_warm", WW'(window_warm), WW'(1));
        tick();
        check("warm_count", WW'(window_count), WW'(3));
        check("warm_count_sat", WW'(s_window_count), WW'(3));

        // Back-pressure
        fin_ready = 1'b0;
        send(32'h04);
        feature_valid = 1'b1;
        feature_in    = 32'h05;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready", WW'(feature_ready), WW'(0));
            check("bp_top", features_top, win3(32'h04, 32'h03, 32'h02));
        end
        @(posedge clk);
        #1;
        fin_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", WW'(feature_ready), WW'(1));
        model_accept(32'h05);
        tick();
        feature_valid = 1'b0;
        check("bp_nobubble_valid", WW'(fin_valid), WW'(1));
        check("bp_nobubble_top", features_top, win3(32'h05, 32'h04, 32'h03));
        tick();
        check("bp_count", WW'(window_count), WW'(5));

        // Full rate after a clean session
        do_clear();
        fin_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(FW'(32'h10 + i));
        tick();
        check("full_count", WW'(window_count), WW'(20));
        check("full_valid_drained", WW'(fin_valid), WW'(0));

        // Clear with a pending window
        fin_ready = 1'b0;
        send(32'hA0);
        do_clear();
        fin_ready = 1'b1;
        send(32'hB0);
        check("g0_top", features_top, win3(32'hB0, 32'h00, 32'h00));
        check("g0_warm", WW'(window_warm), WW'(0));
        tick();
        check("g0_count", WW'(window_count), WW'(1));

        // Saturation of the 3-bit counter
        do_clear();
        fin_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(FW'(32'h40 + i));
            tick();
            check("sat_count", WW'(s_window_count), WW'((i + 1 > 7) ? 7 : i + 1));
            check("sat_main_count", WW'(window_count), WW'(i + 1));
        end

        // Reset in the middle of a pending window
        fin_ready = 1'b0;
        send(32'hC0);
        rst = 1'b1;
        tick();
        check("midrst_ready", WW'(feature_ready), WW'(0));
        check("midrst_valid", WW'(fin_valid), WW'(0));
        check("midrst_top", features_top, WW'(0));
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_post_ready", WW'(feature_ready), WW'(1));
        fin_ready = 1'b1;
        send(32'hD0);
        check("midrst_first_top", features_top, win3(32'hD0, 32'h00, 32'h00));
        tick();

        check("sb_empty", WW'(sb_q.size()), WW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
